riscv_single_cycle: RTL and testbench
=====================================

Name: riscv_single_cycle

Overview:
- Single-cycle RV32I-subset processor core; every instruction fetches, decodes, executes and writes back in one clock.
- Contains its own instruction memory (read-only at run time, preloaded by the bench) and data memory.
- Top-level block with no I/O other than clock and reset; the bench checks results by hierarchical access to internal memories.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words.
- DMEM_DEPTH, 64, number of 32-bit data memory entries; entries are indexed directly by byte address.
- XLEN, 32, datapath and register width.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- areset  input  1  asynchronous, active-low reset.

Behaviour:
- Required hierarchy:
  - instance instr_mem, holding array RAM[0:IMEM_DEPTH-1] of 32-bit words, loaded with $readmemh.
  - instance data_mem, holding array data_memory[0:DMEM_DEPTH-1] of 32 bits.
- Reset (areset=0, asynchronous):
  - PC=0.
  - All 32 registers = 0.
  - Data memory and instruction memory are not cleared.
  - On release, the first rising edge executes the instruction at PC 0.
- Fetch: instr = RAM[PC[log2(IMEM_DEPTH)+1:2]]; combinational read.
- PC update each rising edge:
  - PC+4 by default.
  - PC+immB for a taken branch.
  - PC+immJ for JAL.
  - PC wraps modulo 2^32.
- Register file:
  - 2 combinational read ports, 1 write port written on the rising edge.
  - x0 always reads 0; writes to x0 are discarded.
- Immediates, all sign-extended from instr[31]: I, S, B (bit0=0) and J (bit0=0) formats.
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB (funct7[5]=1), AND, OR, XOR, SLT (signed).
  - I-type ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI.
  - LW (0000011).
  - SW (0100011).
  - BEQ, BNE (1100011).
  - JAL (1101111): rd = PC+4.
- ALU:
  - 32-bit; the result wraps on overflow.
  - SLT/SLTI yield 1 or 0 by signed compare.
  - Zero flag drives the branch decision: BEQ is taken when rs1==rs2, BNE when rs1!=rs2.
- Data memory:
  - addr = ALU result (rs1+imm); entry index = addr[log2(DMEM_DEPTH)-1:0] (byte address used directly as index, full 32-bit entry).
  - LW reads combinationally and writes rd the same cycle.
  - SW writes rs2 on the rising edge.
  - Out-of-range bits are ignored (wrap).
- Any unsupported or illegal opcode executes as a NOP: no register or memory write, PC+4.
- Reset asserted mid-instruction: PC and registers clear immediately; no partial write occurs after the reset edge; data memory keeps its contents.

Optional Feature:
- Macro RISCV_LUI_EN.
- Defined: LUI (opcode 0110111) writes rd = {instr[31:12],12'b0}, and AUIPC (0010111) writes rd = PC + {instr[31:12],12'b0}.
- Undefined: both opcodes are NOPs (PC+4, no register write).

Test Plan:
- Fibonacci:
  - Stimulus: preload the Fibonacci program (computes 1,2,3,5,...). Assert areset low for one negedge, release, run 83 clock cycles.
  - Required response: data_memory[0,4,8,...,36] = 1,2,3,5,8,13,21,34,55,89 exactly.
- ALU/x0:
  - Stimulus: ADDI x1,x0,-5; ADDI x2,x0,3; SUB x3,x1,x2; SLT x4,x1,x2; ADDI x0,x0,7; SW x3,0(x0); SW x4,4(x0); SW x0,8(x0).
  - Required response: data_memory[0]=0xFFFFFFF8, [4]=1, [8]=0.
- Branches:
  - Stimulus: BEQ on equal registers skipping one ADDI, BNE on equal registers not taken.
  - Required response: only the non-skipped ADDI writes are visible in stored results.
- JAL:
  - Stimulus: JAL x1,+8 at PC 0x10.
  - Required response: x1=0x14, next PC=0x18, instruction at 0x14 not executed.
- Reset mid-run:
  - Stimulus: pull areset low mid-program for one cycle.
  - Required response: PC=0 and registers read 0 immediately; the program restarts from 0 and ends with the same Fibonacci memory image.
- Illegal opcode:
  - Stimulus: instruction word 0x00000000.
  - Required response: treated as NOP; PC advances by 4; no state change.

Source files
------------

// File: rtl/riscv_single_cycle.sv
// riscv_single_cycle: single-cycle RV32I-subset core. Each rising clock edge
// fetches, decodes, executes and retires one instruction.
//
// Ports:
//   clk     in  1  sole clock, all state updates on the rising edge
//   areset  in  1  asynchronous active-low reset (PC and registers clear)
//
// Hierarchy:
//   instr_mem.RAM[0:IMEM_DEPTH-1]           read-only at run time, loaded from outside
//   data_mem.data_memory[0:DMEM_DEPTH-1]    indexed directly by byte address
//
// Build option: define RISCV_LUI_EN to execute LUI and AUIPC; without it both
// opcodes retire as NOPs.

// Instruction memory: combinational word read. RAM has no run-time writer;
// the program is loaded into it by the environment before reset is released.
module riscv_imem #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic [$clog2(IMEM_DEPTH)-1:0] i_addr,
  output logic [31:0]                   o_instr
);
  logic [31:0] RAM [0:IMEM_DEPTH-1];

  assign o_instr = RAM[i_addr];
endmodule

// Data memory: combinational read, write on the rising edge. Not reset.
module riscv_dmem #(
  parameter int DMEM_DEPTH = 64,
  parameter int XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(DMEM_DEPTH)-1:0] i_addr,
  input  logic [XLEN-1:0]               i_wdata,
  output logic [XLEN-1:0]               o_rdata
);
  logic [XLEN-1:0] data_memory [0:DMEM_DEPTH-1];

  always_ff @(posedge clk)
    if (i_we) data_memory[i_addr] <= i_wdata;

  assign o_rdata = data_memory[i_addr];
endmodule

module riscv_single_cycle #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter int XLEN       = 32
) (
  input  logic clk,
  input  logic areset
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef RISCV_LUI_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_LUI, WB_AUIPC
  } wb_sel_e;

  typedef struct packed {
    logic    rf_we;
    logic    mem_we;
    logic    alu_imm;   // ALU operand B from immediate instead of rs2
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    logic    br;
    logic    br_ne;
    logic    jal;
  } ctrl_t;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_regs [0:31];

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_alu_b, w_alu_res;
  logic [XLEN-1:0] w_mem_rdata, w_wb, w_pc4, w_pc_next;
  logic            w_zero, w_taken;
  ctrl_t           w_ctrl;

  // ---- fetch ----
  riscv_imem #(.IMEM_DEPTH(IMEM_DEPTH)) instr_mem (
    .i_addr  (r_pc[IAW+1:2]),
    .o_instr (w_instr)
  );

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  // Signed size casts sign-extend from instr[31].
  assign w_imm_i = XLEN'($signed(w_instr[31:20]));
  assign w_imm_s = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                  w_instr[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                  w_instr[30:21], 1'b0}));
`ifdef RISCV_LUI_EN
  logic [XLEN-1:0] w_imm_u;
  assign w_imm_u = XLEN'($signed({w_instr[31:12], 12'b0}));
`endif

  // ---- decode: anything not matched stays a NOP (no writes, PC+4) ----
  always_comb begin
    w_ctrl.rf_we   = 1'b0;
    w_ctrl.mem_we  = 1'b0;
    w_ctrl.alu_imm = 1'b0;
    w_ctrl.alu_op  = ALU_ADD;
    w_ctrl.wb_sel  = WB_ALU;
    w_ctrl.br      = 1'b0;
    w_ctrl.br_ne   = 1'b0;
    w_ctrl.jal     = 1'b0;
    w_imm          = w_imm_i;
    case (w_opcode)
      OP_R: begin
        w_ctrl.rf_we = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = w_instr[30] ? ALU_SUB : ALU_ADD;
          3'b111:  w_ctrl.alu_op = ALU_AND;
          3'b110:  w_ctrl.alu_op = ALU_OR;
          3'b100:  w_ctrl.alu_op = ALU_XOR;
          3'b010:  w_ctrl.alu_op = ALU_SLT;
          default: w_ctrl.rf_we  = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_ctrl.rf_we   = 1'b1;
        w_ctrl.alu_imm = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = ALU_ADD;
          3'b111:  w_ctrl.alu_op = ALU_AND;
          3'b110:  w_ctrl.alu_op = ALU_OR;
          3'b100:  w_ctrl.alu_op = ALU_XOR;
          3'b010:  w_ctrl.alu_op = ALU_SLT;
          default: w_ctrl.rf_we  = 1'b0;
        endcase
      end
      OP_LOAD: if (w_funct3 == 3'b010) begin
        w_ctrl.rf_we   = 1'b1;
        w_ctrl.alu_imm = 1'b1;
        w_ctrl.wb_sel  = WB_MEM;
      end
      OP_STORE: if (w_funct3 == 3'b010) begin
        w_ctrl.mem_we  = 1'b1;
        w_ctrl.alu_imm = 1'b1;
        w_imm          = w_imm_s;
      end
      OP_BR: if (w_funct3[2:1] == 2'b00) begin
        // BEQ/BNE: subtract and use the zero flag
        w_ctrl.br     = 1'b1;
        w_ctrl.br_ne  = w_funct3[0];
        w_ctrl.alu_op = ALU_SUB;
        w_imm         = w_imm_b;
      end
      OP_JAL: begin
        w_ctrl.rf_we  = 1'b1;
        w_ctrl.jal    = 1'b1;
        w_ctrl.wb_sel = WB_PC4;
        w_imm         = w_imm_j;
      end
`ifdef RISCV_LUI_EN
      OP_LUI: begin
        w_ctrl.rf_we  = 1'b1;
        w_ctrl.wb_sel = WB_LUI;
      end
      OP_AUIPC: begin
        w_ctrl.rf_we  = 1'b1;
        w_ctrl.wb_sel = WB_AUIPC;
      end
`endif
      default: ;
    endcase
  end

  // ---- register file ----
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_ctrl.rf_we && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_wb;
    end
  end

  // ---- ALU ----
  assign w_alu_b = w_ctrl.alu_imm ? w_imm : w_rs2_val;

  always_comb begin
    w_alu_res = '0;
    case (w_ctrl.alu_op)
      ALU_ADD: w_alu_res = w_rs1_val + w_alu_b;
      ALU_SUB: w_alu_res = w_rs1_val - w_alu_b;
      ALU_AND: w_alu_res = w_rs1_val & w_alu_b;
      ALU_OR:  w_alu_res = w_rs1_val | w_alu_b;
      ALU_XOR: w_alu_res = w_rs1_val ^ w_alu_b;
      ALU_SLT: w_alu_res = XLEN'($signed(w_rs1_val) < $signed(w_alu_b));
      default: w_alu_res = '0;
    endcase
  end

  assign w_zero = (w_alu_res == '0);

  // ---- data memory ----
  // Store enable is qualified by areset so a clock edge seen while reset is
  // held cannot complete a store from the interrupted instruction.
  riscv_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .XLEN(XLEN)) data_mem (
    .clk     (clk),
    .i_we    (w_ctrl.mem_we & areset),
    .i_addr  (w_alu_res[DAW-1:0]),
    .i_wdata (w_rs2_val),
    .o_rdata (w_mem_rdata)
  );

  // ---- write-back ----
  assign w_pc4 = r_pc + XLEN'(4);

  always_comb begin
    w_wb = w_alu_res;
    case (w_ctrl.wb_sel)
      WB_MEM:   w_wb = w_mem_rdata;
      WB_PC4:   w_wb = w_pc4;
`ifdef RISCV_LUI_EN
      WB_LUI:   w_wb = w_imm_u;
      WB_AUIPC: w_wb = r_pc + w_imm_u;
`endif
      default:  w_wb = w_alu_res;
    endcase
  end

  // ---- next PC ----
  assign w_taken   = w_ctrl.br & (w_ctrl.br_ne ? ~w_zero : w_zero);
  assign w_pc_next = (w_taken || w_ctrl.jal) ? (r_pc + w_imm) : w_pc4;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) r_pc <= '0;
    else         r_pc <= w_pc_next;
  end
endmodule

// File: tb/tb_riscv_single_cycle.sv
module tb_riscv_single_cycle;
  logic clk = 1'b0;
  logic areset = 1'b1;

  riscv_single_cycle dut (.clk(clk), .areset(areset));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    int          addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] ILLEGAL_WORD = 32'h0000_0000;

  // ---- tiny assembler ----
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), OP_IMM};
  endfunction

  function automatic logic [31:0] rtype(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(int rd, int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] utype(int imm20, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic int nonzero_regs();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (dut.r_regs[i] !== 32'h0) n++;
    return n;
  endfunction

  // Holds reset across one rising edge while the program image is loaded.
  task automatic load_and_reset();
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 64; i++) dut.instr_mem.RAM[i] = 32'h0;
    foreach (prog[i]) dut.instr_mem.RAM[i] = prog[i];
    @(negedge clk);
    areset = 1'b1;
  endtask

  task automatic build_fib();
    int fib[10] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
    prog = {};
    prog.push_back(addi(1, 0, 1));
    prog.push_back(addi(2, 0, 2));
    prog.push_back(addi(3, 0, 0));
    prog.push_back(addi(4, 0, 40));
    prog.push_back(sw(1, 3, 0));             // 0x10 loop
    prog.push_back(rtype(0, 2, 1, 0, 5));    // x5 = x1 + x2
    prog.push_back(addi(1, 2, 0));
    prog.push_back(addi(2, 5, 0));
    prog.push_back(addi(3, 3, 4));
    prog.push_back(br(1, 3, 4, -20));        // BNE x3,x4 -> 0x10
    prog.push_back(jal(0, 0));               // halt
    for (int k = 0; k < 10; k++) sb.push_back('{"fib", 4 * k, 32'(fib[k])});
  endtask

  task automatic test_reset();
    #2 areset = 1'b0;
    #1;
    vectors++;
    if (dut.r_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h expected 00000000", dut.r_pc);
    end
    vectors++;
    if (nonzero_regs() != 0) begin
      miscompares++;
      $display("FAIL reset_regs: %0d nonzero registers, expected 0", nonzero_regs());
    end
    @(negedge clk);
    vectors++;
    if (dut.r_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hold_pc: got %h expected 00000000", dut.r_pc);
    end
  endtask

  task automatic test_fibonacci();
    exp_t e;
    build_fib();
    load_and_reset();
    repeat (83) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (dut.data_mem.data_memory[e.addr] !== e.val) begin
        miscompares++;
        $display("FAIL %s dmem[%0d]: got %h expected %h", e.name, e.addr,
                 dut.data_mem.data_memory[e.addr], e.val);
      end
    end
  endtask

  task automatic test_alu_x0();
    exp_t e;
    prog = {};
    prog.push_back(addi(1, 0, -5));
    prog.push_back(addi(2, 0, 3));
    prog.push_back(rtype(32, 2, 1, 0, 3));   // SUB x3,x1,x2
    prog.push_back(rtype(0, 2, 1, 2, 4));    // SLT x4,x1,x2
    prog.push_back(addi(0, 0, 7));           // write to x0 discarded
    prog.push_back(sw(3, 0, 0));
    prog.push_back(sw(4, 0, 4));
    prog.push_back(sw(0, 0, 8));
    prog.push_back(jal(0, 0));
    sb.push_back('{"alu_sub", 0, 32'hFFFF_FFF8});
    sb.push_back('{"alu_slt", 4, 32'h1});
    sb.push_back('{"alu_x0",  8, 32'h0});
    load_and_reset();
    repeat (12) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (dut.data_mem.data_memory[e.addr] !== e.val) begin
        miscompares++;
        $display("FAIL %s dmem[%0d]: got %h expected %h", e.name, e.addr,
                 dut.data_mem.data_memory[e.addr], e.val);
      end
    end
    vectors++;
    if (dut.r_regs[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_reg: got %h expected 00000000", dut.r_regs[0]);
    end
  endtask

  task automatic test_branches();
    exp_t e;
    prog = {};
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 0, 5));
    prog.push_back(br(0, 1, 2, 8));          // BEQ taken, skips next
    prog.push_back(addi(3, 0, 1));           // skipped
    prog.push_back(br(1, 1, 2, 8));          // BNE not taken
    prog.push_back(addi(4, 0, 2));           // executed
    prog.push_back(sw(3, 0, 12));
    prog.push_back(sw(4, 0, 16));
    prog.push_back(jal(0, 0));
    sb.push_back('{"beq_skip",   12, 32'h0});
    sb.push_back('{"bne_fallth", 16, 32'h2});
    load_and_reset();
    repeat (12) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (dut.data_mem.data_memory[e.addr] !== e.val) begin
        miscompares++;
        $display("FAIL %s dmem[%0d]: got %h expected %h", e.name, e.addr,
                 dut.data_mem.data_memory[e.addr], e.val);
      end
    end
  endtask

  task automatic test_jal();
    prog = {};
    repeat (4) prog.push_back(addi(0, 0, 0));
    prog.push_back(jal(1, 8));               // 0x10
    prog.push_back(addi(6, 0, 1));           // 0x14 must not run
    prog.push_back(addi(7, 0, 3));           // 0x18
    prog.push_back(jal(0, 0));
    load_and_reset();
    repeat (4) @(negedge clk);
    vectors++;
    if (dut.r_pc !== 32'h10) begin
      miscompares++;
      $display("FAIL jal_pc_before: got %h expected 00000010", dut.r_pc);
    end
    @(negedge clk);
    vectors++;
    if (dut.r_pc !== 32'h18) begin
      miscompares++;
      $display("FAIL jal_target: got %h expected 00000018", dut.r_pc);
    end
    vectors++;
    if (dut.r_regs[1] !== 32'h14) begin
      miscompares++;
      $display("FAIL jal_link: got %h expected 00000014", dut.r_regs[1]);
    end
    @(negedge clk);
    vectors++;
    if (dut.r_regs[6] !== 32'h0) begin
      miscompares++;
      $display("FAIL jal_skipped: got %h expected 00000000", dut.r_regs[6]);
    end
    vectors++;
    if (dut.r_regs[7] !== 32'h3) begin
      miscompares++;
      $display("FAIL jal_landing: got %h expected 00000003", dut.r_regs[7]);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_x9, exp_x10;
`ifdef RISCV_LUI_EN
    exp_x9  = 32'h1234_5000;
    exp_x10 = 32'h0000_1008;
`else
    exp_x9  = 32'h0;
    exp_x10 = 32'h0;
`endif
    prog = {};
    prog.push_back(ILLEGAL_WORD);
    prog.push_back(utype(20'h12345, 9, OP_LUI));
    prog.push_back(utype(1, 10, OP_AUIPC));  // at PC 8
    prog.push_back(jal(0, 0));
    load_and_reset();
    @(negedge clk);
    vectors++;
    if (dut.r_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL illegal_pc: got %h expected 00000004", dut.r_pc);
    end
    vectors++;
    if (nonzero_regs() != 0) begin
      miscompares++;
      $display("FAIL illegal_regs: %0d nonzero registers, expected 0", nonzero_regs());
    end
    // Last write to dmem[0] was the SUB result from the ALU program.
    vectors++;
    if (dut.data_mem.data_memory[0] !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL illegal_dmem: got %h expected fffffff8", dut.data_mem.data_memory[0]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (dut.r_pc !== 32'hC) begin
      miscompares++;
      $display("FAIL upper_pc: got %h expected 0000000c", dut.r_pc);
    end
    vectors++;
    if (dut.r_regs[9] !== exp_x9) begin
      miscompares++;
      $display("FAIL lui: got %h expected %h", dut.r_regs[9], exp_x9);
    end
    vectors++;
    if (dut.r_regs[10] !== exp_x10) begin
      miscompares++;
      $display("FAIL auipc: got %h expected %h", dut.r_regs[10], exp_x10);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    build_fib();
    load_and_reset();
    repeat (30) @(negedge clk);
    areset = 1'b0;
    #1;
    vectors++;
    if (dut.r_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL midrun_pc: got %h expected 00000000", dut.r_pc);
    end
    vectors++;
    if (nonzero_regs() != 0) begin
      miscompares++;
      $display("FAIL midrun_regs: %0d nonzero registers, expected 0", nonzero_regs());
    end
    @(negedge clk);
    areset = 1'b1;
    repeat (83) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (dut.data_mem.data_memory[e.addr] !== e.val) begin
        miscompares++;
        $display("FAIL restart_%s dmem[%0d]: got %h expected %h", e.name, e.addr,
                 dut.data_mem.data_memory[e.addr], e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_alu_x0();
    test_branches();
    test_jal();
    test_illegal();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
